// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem read, skid buffer and IF/ID register.
// Jump/Branch feedback from decode redirects the PC and squashes wrong-path reads.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        alu_zero,
   output logic [31:0] instr_out,
   output logic [31:0] pc_plus4_out,
   output logic        instr_valid
);

   typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_WAIT, ST_HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;
   logic [31:0] req_pc4_q, req_pc4_d;
   logic        discard_q, discard_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;

   logic        accept;
   logic        consume;
   logic        redirect;
   logic        if_free;
   logic [31:0] target;

   assign accept   = req_q && imem_ready;
   assign consume  = valid_q && !stall;
   assign redirect = consume && (Jump || (Branch && alu_zero));
   assign if_free  = !valid_q || consume;
   // Jump wins over a simultaneous taken branch.
   assign target   = Jump ? {pc4_q[31:28], instr_q[25:0], 2'b00}
                          : pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      req_pc4_d    = req_pc4_q;
      discard_d    = discard_q;

      if (consume) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_RST: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (accept) begin
               pc_d      = pc_q + 32'd4;
               req_pc4_d = pc_q + 32'd4;
               state_d   = ST_WAIT;
               if (redirect) begin
                  discard_d = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (discard_q || redirect) begin
                  discard_d = 1'b0;
                  state_d   = ST_FETCH;
               end else if (if_free) begin
                  instr_d = imem_rdata;
                  pc4_d   = req_pc4_q;
                  valid_d = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  skid_instr_d = imem_rdata;
                  skid_pc4_d   = req_pc4_q;
                  state_d      = ST_HOLD;
               end
            end else if (redirect) begin
               discard_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               state_d = ST_FETCH;
            end else if (if_free) begin
               instr_d = skid_instr_q;
               pc4_d   = skid_pc4_q;
               valid_d = 1'b1;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_RST;
         end
      endcase

      if (redirect) begin
         pc_d = target;
      end

      // Request and address are registered copies of the next state and next PC.
      req_d  = (state_d == ST_FETCH);
      addr_d = pc_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RST;
         pc_q         <= RESET_PC;
         instr_q      <= 32'h0;
         pc4_q        <= 32'h0;
         valid_q      <= 1'b0;
         skid_instr_q <= 32'h0;
         skid_pc4_q   <= 32'h0;
         req_pc4_q    <= 32'h0;
         discard_q    <= 1'b0;
         req_q        <= 1'b0;
         addr_q       <= RESET_PC;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
         req_pc4_q    <= req_pc4_d;
         discard_q    <= discard_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
      end
   end

   assign imem_req     = req_q;
   assign imem_addr    = addr_q;
   assign instr_out    = instr_q;
   assign pc_plus4_out = pc4_q;
   assign instr_valid  = valid_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage with a registered IF/ID output, sitting directly upstream of the main control decoder. It keeps the program counter and issues one word-aligned read at a time to instruction memory. It presents the fetched instruction (opcode = `instr_out[31:26]`) to decode. It takes the decoder's `Jump`/`Branch` decisions plus the ALU zero flag back to redirect the PC and squash wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Must be word-aligned.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  32  read address, always word-aligned
- `imem_ready`  in  1  memory accepts the request this cycle when `imem_req && imem_ready`
- `imem_rvalid`  in  1  read data valid; arrives ≥1 cycle after acceptance, in order
- `imem_rdata`  in  32  read data
- `stall`  in  1  decode cannot take the IF/ID word this cycle
- `Jump`  in  1  from control decoder, for `instr_out`
- `Branch`  in  1  from control decoder, for `instr_out`
- `alu_zero`  in  1  ALU zero flag for the branch compare of `instr_out`
- `instr_out`  out  32  IF/ID instruction
- `pc_plus4_out`  out  32  IF/ID address of `instr_out` + 4
- `instr_valid`  out  1  IF/ID holds a valid instruction

## Operation
- Registers: `pc` (next fetch address), the IF/ID trio, a one-word skid buffer, a `discard` flag, and a 2-bit state.
- States and transitions:
  - RST: entered by reset, lasts one cycle, then goes to FETCH.
  - FETCH: drives `imem_req=1` and `imem_addr=pc`. On acceptance it sets `pc <= pc+4` and goes to WAIT.
  - WAIT: waits for `imem_rvalid`.
    - If `discard` is set, the data is dropped, `discard` is cleared, and the state goes to FETCH.
    - Otherwise, if IF/ID is free or is consumed this cycle, the data loads into IF/ID and the state goes to FETCH.
    - Otherwise the data goes into the skid buffer and the state goes to HOLD.
  - HOLD: loads the buffer into IF/ID when IF/ID is free or consumed, then goes to FETCH.
- `imem_req` is asserted only in FETCH, so at most one request is outstanding.
- IF/ID is consumed when `instr_valid && !stall`.
- `pc_plus4_out` equals the fetch address of the word + 4, captured at acceptance.
- A redirect happens when the word is consumed and `Jump || (Branch && alu_zero)`. Jump has priority.
  - Jump target: {`pc_plus4_out[31:28]`, `instr_out[25:0]`, 2'b00}.
  - Branch target: `pc_plus4_out` + (sign-extended `instr_out[15:0]` << 2), computed modulo 2^32.
- On a redirect:
  - `pc` <= target and `instr_valid` <= 0.
  - In WAIT with no `rvalid` this cycle, `discard` is set.
  - In WAIT with `rvalid` this cycle, the data is dropped and the state goes to FETCH.
  - In HOLD, the buffer is dropped and the state goes to FETCH.
  - In FETCH with acceptance this cycle, the accepted read is marked `discard`. `pc` takes the target, not pc+4.
- `stall` with no redirect: IF/ID holds its value. Fetch continues until the skid buffer is full, then the block waits in HOLD.
- `Jump`/`Branch`/`alu_zero` are ignored while `instr_valid=0` or `stall=1`.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_out`=32'h0 (NOP; opcode 0), `pc_plus4_out`=0, `instr_valid`=0, `pc`=`RESET_PC`, `discard`=0, state RST.
- Reset assertion takes effect immediately (asynchronous). Any in-flight read completing after reset release is ignored by the WAIT logic because the state is RST/FETCH.
- Latency: request accepted at cycle T, `rvalid` at T+k (k≥1), `instr_valid`=1 from T+k+1.
- Next `imem_req` is asserted at T+k+1.
- With zero wait states (`imem_ready`=1, k=1), throughput is one instruction per 2 cycles.
- Redirect at cycle R: `instr_valid`=0 at R+1. The first `imem_req` to the target address is issued at R+1, or later if a discarded read is still pending.
- Every output is a register. There is no combinational path from inputs to outputs.

## Test plan
- Reset release with `RESET_PC`=0x100, memory with 0 wait states and k=1 → requests to 0x100, 0x104, 0x108. `instr_out`/`pc_plus4_out` show (word@0x100, 0x104), and so on, one every 2 cycles.
- `stall` held 6 cycles with a valid word in IF/ID → `instr_out` stays stable. At most one further word is buffered and no extra request is issued. Releasing the stall delivers the words in order with none lost.
- Jump instruction 0x0800_0040 with `pc_plus4_out`=0x1000_0008 → next request to 0x1000_0100. The in-flight word from 0x1000_0008 is never shown valid.
- Branch with imm 0xFFFE, `pc_plus4_out`=0x200, `alu_zero`=1 → next fetch at 0x1F8. The same branch with `alu_zero`=0 → fetch continues sequentially.
- Redirect in the same cycle as `imem_rvalid`, and in the same cycle as request acceptance → in both cases the wrong-path data is dropped and the target is the next valid word.
- `rst_n` pulsed low mid-WAIT → outputs return to their reset values at once. The late `rvalid` is ignored. Fetch restarts at `RESET_PC`.
- PC wrap: start at 0xFFFF_FFF8 → requests to 0xFFFF_FFFC, then 0x0000_0000.
